// File: rtl/clock_pkg.sv
// Shared state encodings, blank patterns and default timing constants for the clock time-set controller.
package clock_pkg;

   typedef enum logic [1:0] {
      MODE_RUN     = 2'b00,
      MODE_SET_MIN = 2'b01,
      MODE_SET_SEC = 2'b10,
      MODE_BAD     = 2'b11
   } mode_t;

   localparam int BLINK_DIV_DEF  = 5;
   localparam int REPEAT_DLY_DEF = 5;
   localparam int REPEAT_PER_DEF = 2;

   localparam logic [3:0] BLANK_MIN = 4'b1100;
   localparam logic [3:0] BLANK_SEC = 4'b0011;

   // The unreachable code falls back to RUN.
   function automatic mode_t next_mode(input mode_t m);
      case (m)
         MODE_RUN:     return MODE_SET_MIN;
         MODE_SET_MIN: return MODE_SET_SEC;
         default:      return MODE_RUN;
      endcase
   endfunction

endpackage

// File: rtl/clkset_repeat.sv
// Auto-repeat generator: one-cycle pulse after REPEAT_DLY ticks of held key, then every REPEAT_PER ticks.
// Combinational pulse (caller registers it); counter clears whenever active or up_held drops.
module clkset_repeat
   import clock_pkg::*;
#(
   parameter int REPEAT_DLY = REPEAT_DLY_DEF,
   parameter int REPEAT_PER = REPEAT_PER_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic en_tick,
   input  logic up_held,
   input  logic active,
   output logic rpt
);

   localparam int TOP = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
   localparam int CW  = (TOP > 1) ? $clog2(TOP + 1) : 1;
   localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DLY - 1);
   localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PER - 1);

   logic [CW-1:0] cnt_q, cnt_d;
   logic          armed_q, armed_d;
   logic          hit;

   assign hit = (cnt_q == (armed_q ? PER_LAST : DLY_LAST));
   assign rpt = active && up_held && en_tick && hit;

   always_comb begin
      cnt_d   = cnt_q;
      armed_d = armed_q;
      if (!active || !up_held) begin
         cnt_d   = '0;
         armed_d = 1'b0;
      end else if (en_tick) begin
         if (hit) begin
            cnt_d   = '0;
            armed_d = 1'b1;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt_q   <= '0;
         armed_q <= 1'b0;
      end else begin
         cnt_q   <= cnt_d;
         armed_q <= armed_d;
      end
   end

endmodule

// File: rtl/clock_set_ctrl.sv
// Clock time-set controller: RUN/SET_MIN/SET_SEC FSM, blink blanking, registered pulses 1 cycle after input.
// No backpressure (pulse inputs); auto-repeat of held up key only when AUTO_REPEAT_EN is defined.
module clock_set_ctrl
   import clock_pkg::*;
#(
   parameter int BLINK_DIV  = BLINK_DIV_DEF,
   parameter int REPEAT_DLY = REPEAT_DLY_DEF,
   parameter int REPEAT_PER = REPEAT_PER_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en1hz,
   input  logic       en_tick,
   input  logic       btn_mode,
   input  logic       btn_up,
   input  logic       btn_clr,
   input  logic       up_held,
   output logic       sec_en,
   output logic       min_inc,
   output logic       clr_out,
   output logic [3:0] blank,
   output logic [1:0] mode
);

   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [BW-1:0] DIV_LAST = BW'(BLINK_DIV - 1);

   mode_t         state_q, state_d;
   logic          sec_en_q, sec_en_d, min_inc_q, min_inc_d, clr_q, clr_d;
   logic [3:0]    blank_q, blank_d;
   logic [BW-1:0] div_q, div_d;
   logic          phase_q, phase_d, hold_q, hold_d;
   logic          in_set, mode_chg, up_evt, rpt_evt;

   assign in_set   = (state_q == MODE_SET_MIN) || (state_q == MODE_SET_SEC);
   assign mode_chg = (state_d != state_q);
   assign up_evt   = in_set && (btn_up || rpt_evt) && !btn_mode && !btn_clr;

`ifdef AUTO_REPEAT_EN
   clkset_repeat #(
      .REPEAT_DLY (REPEAT_DLY),
      .REPEAT_PER (REPEAT_PER)
   ) u_repeat (
      .clk     (clk),
      .rst     (rst),
      .en_tick (en_tick),
      .up_held (up_held),
      .active  (in_set && !mode_chg),
      .rpt     (rpt_evt)
   );
`else
   localparam int unused_rpt_cfg = REPEAT_DLY + REPEAT_PER;
   logic unused_held;
   assign unused_held = up_held;
   assign rpt_evt     = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= MODE_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (btn_mode || state_q == MODE_BAD) begin
         state_d = next_mode(state_q);
      end
   end

   // An accepted up event restarts the divider with hold set, so the digits stay lit for a full period.
   always_comb begin
      div_d   = div_q;
      phase_d = phase_q;
      hold_d  = hold_q;
      if (mode_chg || !in_set) begin
         div_d   = '0;
         phase_d = 1'b0;
         hold_d  = 1'b0;
      end else if (up_evt) begin
         div_d   = '0;
         phase_d = 1'b0;
         hold_d  = 1'b1;
      end else if (en_tick) begin
         if (div_q == DIV_LAST) begin
            div_d = '0;
            if (hold_q) begin
               hold_d = 1'b0;
            end else begin
               phase_d = !phase_q;
            end
         end else begin
            div_d = div_q + BW'(1);
         end
      end
   end

   always_comb begin
      sec_en_d  = 1'b0;
      min_inc_d = 1'b0;
      clr_d     = btn_clr;
      blank_d   = 4'b0000;
      case (state_q)
         MODE_RUN:     sec_en_d  = en1hz;
         MODE_SET_MIN: min_inc_d = up_evt;
         MODE_SET_SEC: sec_en_d  = up_evt;
         default:      ;
      endcase
      if (phase_d) begin
         if (state_d == MODE_SET_MIN) begin
            blank_d = BLANK_MIN;
         end else if (state_d == MODE_SET_SEC) begin
            blank_d = BLANK_SEC;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         div_q     <= '0;
         phase_q   <= 1'b0;
         hold_q    <= 1'b0;
         sec_en_q  <= 1'b0;
         min_inc_q <= 1'b0;
         clr_q     <= 1'b0;
         blank_q   <= 4'b0000;
      end else begin
         div_q     <= div_d;
         phase_q   <= phase_d;
         hold_q    <= hold_d;
         sec_en_q  <= sec_en_d;
         min_inc_q <= min_inc_d;
         clr_q     <= clr_d;
         blank_q   <= blank_d;
      end
   end

   assign sec_en  = sec_en_q;
   assign min_inc = min_inc_q;
   assign clr_out = clr_q;
   assign blank   = blank_q;
   assign mode    = state_q;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Randomized and directed bench for clock_set_ctrl against a tick-count reference model.
module tb_clock_set_ctrl;
   import clock_pkg::*;

   localparam int BD = 5;
   localparam int RD = 5;
   localparam int RP = 2;

   logic       clk = 1'b0, rst = 1'b0;
   logic       en1hz = 1'b0, en_tick = 1'b0, btn_mode = 1'b0, btn_up = 1'b0, btn_clr = 1'b0, up_held = 1'b0;
   logic       sec_en, min_inc, clr_out;
   logic [3:0] blank;
   logic [1:0] mode;

   int n_chk = 0, n_err = 0;
   int m_mode = 0, m_ticks = 0, m_hold = 0, m_held = 0;
   int mi_cnt = 0, se_cnt = 0;
   logic       e_sec, e_min, e_clr;
   logic [3:0] e_blank;

   always #5 clk = ~clk;

   clock_set_ctrl #(
      .BLINK_DIV  (BD),
      .REPEAT_DLY (RD),
      .REPEAT_PER (RP)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .en1hz    (en1hz),
      .en_tick  (en_tick),
      .btn_mode (btn_mode),
      .btn_up   (btn_up),
      .btn_clr  (btn_clr),
      .up_held  (up_held),
      .sec_en   (sec_en),
      .min_inc  (min_inc),
      .clr_out  (clr_out),
      .blank    (blank),
      .mode     (mode)
   );

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Blink phase from ticks since last restart; an up event pushes the first toggle one period later.
   function automatic bit m_phase();
      if (m_ticks < m_hold) return 1'b0;
      return (((m_ticks - m_hold) / BD) % 2) == 1;
   endfunction

   task automatic model_reset();
      m_mode = 0; m_ticks = 0; m_hold = 0; m_held = 0;
   endtask

   task automatic model_step();
      bit in_set, rpt, up;
      int hn;
      in_set = (m_mode != 0);
      rpt = 1'b0;
`ifdef AUTO_REPEAT_EN
      hn = m_held + 1;
      rpt = in_set && up_held && en_tick && !btn_mode &&
            (hn == RD || (hn > RD && ((hn - RD) % RP) == 0));
      if (!in_set || !up_held || btn_mode) m_held = 0;
      else if (en_tick) m_held = hn;
`else
      hn = 0;
`endif
      up    = in_set && (btn_up || rpt) && !btn_mode && !btn_clr;
      e_clr = btn_clr;
      e_sec = (m_mode == 0) ? en1hz : (m_mode == 2 && up);
      e_min = (m_mode == 1) && up;
      if (btn_mode) begin
         m_mode = (m_mode + 1) % 3; m_ticks = 0; m_hold = 0;
      end else if (up) begin
         m_ticks = 0; m_hold = BD;
      end else if (en_tick && in_set) begin
         m_ticks++;
      end
      e_blank = (m_mode == 0 || !m_phase()) ? 4'b0000 : ((m_mode == 1) ? 4'b1100 : 4'b0011);
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      chk_eq({tag, ".sec_en"},  sec_en,  e_sec);
      chk_eq({tag, ".min_inc"}, min_inc, e_min);
      chk_eq({tag, ".clr_out"}, clr_out, e_clr);
      chk_eq({tag, ".blank"},   blank,   e_blank);
      chk_eq({tag, ".mode"},    mode,    m_mode[1:0]);
      if (min_inc) mi_cnt++;
      if (sec_en)  se_cnt++;
      en1hz = 1'b0; en_tick = 1'b0; btn_mode = 1'b0; btn_up = 1'b0; btn_clr = 1'b0;
   endtask

   task automatic goto_mode(input int t);
      for (int i = 0; i < 3 && m_mode != t; i++) begin
         btn_mode = 1'b1;
         cycle("goto");
      end
      chk_eq("goto_mode", mode, t[1:0]);
   endtask

   task automatic ticks(input string tag, input int n);
      for (int i = 0; i < n; i++) begin
         en_tick = 1'b1;
         cycle(tag);
         cycle(tag);
      end
   endtask

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk_eq("rst.sec_en", sec_en, 1'b0);
      chk_eq("rst.min_inc", min_inc, 1'b0);
      chk_eq("rst.clr_out", clr_out, 1'b0);
      chk_eq("rst.blank", blank, 4'b0000);
      chk_eq("rst.mode", mode, 2'b00);
      rst = 1'b1;
      model_reset();

      // Running: three 1 Hz pulses each echoed one cycle later, ticks leave blank at 0.
      se_cnt = 0;
      for (int i = 0; i < 3; i++) begin
         en1hz = 1'b1; en_tick = 1'b1;
         cycle("run");
         cycle("run");
      end
      chk_eq("run.sec_cnt", se_cnt, 3);

      // Set minutes: four up presses, seconds frozen across 1 Hz pulses.
      btn_mode = 1'b1;
      cycle("setmin");
      mi_cnt = 0; se_cnt = 0;
      for (int i = 0; i < 4; i++) begin
         btn_up = 1'b1;
         cycle("setmin.up");
         en1hz = 1'b1;
         cycle("setmin.1hz");
      end
      chk_eq("setmin.min_cnt", mi_cnt, 4);
      chk_eq("setmin.sec_cnt", se_cnt, 0);

      // Set seconds: blink on at 5 ticks, off at 10, up holds digits lit for a full period.
      btn_mode = 1'b1;
      cycle("setsec");
      ticks("blink_on", 5);
      chk_eq("blink.on", blank, 4'b0011);
      ticks("blink_off", 5);
      chk_eq("blink.off", blank, 4'b0000);
      btn_up = 1'b1;
      cycle("blink.up");
      ticks("blink_hold", 9);
      chk_eq("blink.hold", blank, 4'b0000);
      ticks("blink_resume", 1);

      // Clear in SET_SEC swallows a coincident up; clear with mode still advances.
      btn_clr = 1'b1; btn_up = 1'b1;
      cycle("clr_up");
      btn_clr = 1'b1; btn_mode = 1'b1;
      cycle("clr_mode");
      chk_eq("clr_mode.mode", mode, 2'b00);

      // Mode and up together from SET_MIN: transition wins, no increment.
      goto_mode(1);
      btn_mode = 1'b1; btn_up = 1'b1;
      cycle("mode_up");
      chk_eq("mode_up.mode", mode, 2'b10);

      // Held up key for 11 ticks in SET_MIN.
      goto_mode(1);
      mi_cnt = 0;
      up_held = 1'b1;
      ticks("held", 11);
      up_held = 1'b0;
      cycle("held_end");
`ifdef AUTO_REPEAT_EN
      chk_eq("held.min_cnt", mi_cnt, 4);
`else
      chk_eq("held.min_cnt", mi_cnt, 0);
`endif

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         en1hz    = ($urandom_range(0, 7) == 0);
         en_tick  = ($urandom_range(0, 2) == 0);
         btn_mode = ($urandom_range(0, 39) == 0);
         btn_up   = ($urandom_range(0, 9) == 0);
         btn_clr  = ($urandom_range(0, 29) == 0);
         if ($urandom_range(0, 19) == 0) up_held = ~up_held;
         cycle("rand");
      end
      up_held = 1'b0;

      // Reset mid-blink in SET_SEC.
      goto_mode(2);
      for (int i = 0; i < 4 * BD && !m_phase(); i++) ticks("pre_rst", 1);
      chk_eq("pre_rst.blank", blank, 4'b0011);
      #2 rst = 1'b0;
      #1;
      chk_eq("mid_rst.sec_en", sec_en, 1'b0);
      chk_eq("mid_rst.min_inc", min_inc, 1'b0);
      chk_eq("mid_rst.clr_out", clr_out, 1'b0);
      chk_eq("mid_rst.blank", blank, 4'b0000);
      chk_eq("mid_rst.mode", mode, 2'b00);
      @(posedge clk);
      #1 rst = 1'b1;
      model_reset();
      cycle("post_rst");
      en1hz = 1'b1;
      cycle("post_rst.1hz");
      chk_eq("post_rst.sec_en", sec_en, 1'b1);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
